// File: rtl/sonar_sched_pkg.sv
// Shared types for the sonar ping scheduler: FSM state encoding, angle type
// and the "no echo" time-of-flight sentinel helper.
package sonar_sched_pkg;

  localparam int unsigned ANGLE_WIDTH_DEF = 8;

  typedef enum logic [1:0] {IDLE, BURST, LISTEN, REPORT} state_e;

  typedef logic signed [ANGLE_WIDTH_DEF-1:0] angle_t;

  // All-ones value of the given width (widths above 32 saturate at 32 bits).
  function automatic logic [31:0] tof_none(input int unsigned width);
    if (width >= 32) return '1;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/sonar_angle_sweeper.sv
// Beam angle owner: dwells PINGS_PER_ANGLE steps per angle, then sweeps
// ping-pong between ANGLE_MIN and ANGLE_MAX. hold_i restarts the dwell.
module sonar_angle_sweeper
  import sonar_sched_pkg::*;
#(
  parameter int ANGLE_WIDTH     = 8,
  parameter int ANGLE_MIN       = -30,
  parameter int ANGLE_MAX       = 30,
  parameter int ANGLE_STEP      = 1,
  parameter int PINGS_PER_ANGLE = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          step_i,
  input  logic                          hold_i,
  output logic signed [ANGLE_WIDTH-1:0] angle_o
);

  localparam int unsigned DW = $clog2(PINGS_PER_ANGLE + 1);

  typedef logic signed [ANGLE_WIDTH:0] wide_t;
  localparam wide_t MIN_W  = wide_t'(ANGLE_MIN);
  localparam wide_t MAX_W  = wide_t'(ANGLE_MAX);
  localparam wide_t STEP_W = wide_t'(ANGLE_STEP);

  logic [DW-1:0]                 dwell_q, dwell_d;
  logic signed [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic                          up_q, up_d;
  wide_t                         angle_w;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_q <= '0;
      angle_q <= '0;
      up_q    <= 1'b1;
    end else begin
      dwell_q <= dwell_d;
      angle_q <= angle_d;
      up_q    <= up_d;
    end
  end

  always_comb begin
    dwell_d = dwell_q;
    angle_d = angle_q;
    up_d    = up_q;
    angle_w = wide_t'(angle_q);
    if (step_i) begin
      if (hold_i) begin
        dwell_d = '0;
      end else if (dwell_q == DW'(PINGS_PER_ANGLE - 1)) begin
        dwell_d = '0;
        // Direction flips when leaving a limit, so each limit is dwelt once.
        if (up_q) begin
          if (angle_w >= MAX_W) begin
            angle_d = ANGLE_WIDTH'(MAX_W - STEP_W);
            up_d    = 1'b0;
          end else begin
            angle_d = ANGLE_WIDTH'(angle_w + STEP_W);
          end
        end else begin
          if (angle_w <= MIN_W) begin
            angle_d = ANGLE_WIDTH'(MIN_W + STEP_W);
            up_d    = 1'b1;
          end else begin
            angle_d = ANGLE_WIDTH'(angle_w - STEP_W);
          end
        end
      end else begin
        dwell_d = dwell_q + DW'(1);
      end
    end
  end

  assign angle_o = angle_q;

endmodule

// File: rtl/sonar_scan_scheduler.sv
// Sonar ping sequencer: BURST / LISTEN / REPORT with sample strobes, echo
// capture and handshaked hand-off. Define SONAR_SCHED_TRACK_EN to hold angle on hits.
module sonar_scan_scheduler
  import sonar_sched_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES   = 16777216,
  parameter int unsigned BURST_CYCLES    = 524288,
  parameter int unsigned SAMPLE_DIV      = 100,
  parameter int          ANGLE_WIDTH     = 8,
  parameter int          ANGLE_MIN       = -30,
  parameter int          ANGLE_MAX       = 30,
  parameter int          ANGLE_STEP      = 1,
  parameter int unsigned PINGS_PER_ANGLE = 8,
  localparam int unsigned TW = $clog2(PERIOD_CYCLES)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          echo_in,
  output logic                          burst_start_out,
  output logic                          tx_en_out,
  output logic                          listen_out,
  output logic                          sample_trigger_out,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic [TW-1:0]                 time_since_emission_out,
  output logic                          scan_valid_out,
  input  logic                          scan_ready_in,
  output logic signed [ANGLE_WIDTH-1:0] scan_angle_out,
  output logic [TW-1:0]                 scan_tof_out,
  output logic                          scan_hit_out
);

  localparam int unsigned   SW          = $clog2(SAMPLE_DIV + 1);
  localparam logic [TW-1:0] TOF_NONE    = TW'(tof_none(TW));
  localparam logic [TW-1:0] BURST_LAST  = TW'(BURST_CYCLES - 1);
  localparam logic [TW-1:0] PERIOD_LAST = TW'(PERIOD_CYCLES - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);

  state_e                        state_q, state_d;
  logic [TW-1:0]                 cnt_q, cnt_d, tof_q, tof_d;
  logic [SW-1:0]                 samp_q, samp_d;
  logic                          hit_q, hit_d;
  logic                          step, hold;
  logic signed [ANGLE_WIDTH-1:0] angle;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      samp_q  <= '0;
      tof_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      samp_q  <= samp_d;
      tof_q   <= tof_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    samp_d  = samp_q;
    tof_d   = tof_q;
    hit_d   = hit_q;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_in) begin
          state_d = BURST;
          cnt_d   = '0;
          tof_d   = TOF_NONE;
          hit_d   = 1'b0;
        end
      end
      BURST: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == BURST_LAST) begin
          state_d = LISTEN;
          samp_d  = '0;
        end
      end
      LISTEN: begin
        samp_d = (samp_q == SAMPLE_LAST) ? '0 : samp_q + SW'(1);
        if (echo_in && !hit_q) begin
          hit_d = 1'b1;
          tof_d = cnt_q;
        end
        // Counter parks on the last cycle so it never wraps into REPORT.
        if (cnt_q == PERIOD_LAST) state_d = REPORT;
        else                      cnt_d   = cnt_q + TW'(1);
      end
      REPORT: begin
        if (scan_ready_in) begin
          step = 1'b1;
          if (enable_in) begin
            state_d = BURST;
            cnt_d   = '0;
            tof_d   = TOF_NONE;
            hit_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SONAR_SCHED_TRACK_EN
  assign hold = hit_q;
`else
  assign hold = 1'b0;
`endif

  sonar_angle_sweeper #(
    .ANGLE_WIDTH     (ANGLE_WIDTH),
    .ANGLE_MIN       (ANGLE_MIN),
    .ANGLE_MAX       (ANGLE_MAX),
    .ANGLE_STEP      (ANGLE_STEP),
    .PINGS_PER_ANGLE (int'(PINGS_PER_ANGLE))
  ) u_sweeper (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .step_i  (step),
    .hold_i  (hold),
    .angle_o (angle)
  );

  assign burst_start_out         = (state_q == BURST) && (cnt_q == '0);
  assign tx_en_out               = (state_q == BURST);
  assign listen_out              = (state_q == LISTEN);
  assign sample_trigger_out      = (state_q == LISTEN) && (samp_q == '0);
  assign beam_angle_out          = angle;
  assign time_since_emission_out = cnt_q;
  assign scan_valid_out          = (state_q == REPORT);
  assign scan_angle_out          = scan_valid_out ? angle : '0;
  assign scan_tof_out            = scan_valid_out ? tof_q : '0;
  assign scan_hit_out            = scan_valid_out & hit_q;

endmodule
